// File: rtl/fma_exp_pipe.sv
// rtl/fma_exp_pipe.sv - two-stage FMA exponent path: exp_a+exp_b, exponent select and addend shift amount
// Stage 1 forms exp_ab and d = exp_c - exp_ab; stage 2 picks exp_tmp and clamps the addend shift.
module fma_exp_pipe #(
    parameter  int EXP_W   = 8,
    parameter  int MANT_W  = 24,
    parameter  int TAG_W   = 4,
    localparam int OFS     = MANT_W + 3,
    localparam int SHF_MAX = 3 * MANT_W + 2,
    localparam int SHF_W   = $clog2(SHF_MAX + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_mode,
    input  logic [EXP_W-1:0]   exp_a,
    input  logic [EXP_W-1:0]   exp_b,
    input  logic [EXP_W-1:0]   exp_c,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [EXP_W:0]     exp_ab,
    output logic [EXP_W+1:0]   exp_tmp,
    output logic [SHF_W-1:0]   shf_num,
    output logic               c_dom,
    output logic [TAG_W-1:0]   out_tag
);
    localparam int DW = EXP_W + 2;

    logic               s1_valid_q, s1_valid_d;
    logic               s1_mode_q, s1_mode_d;
    logic [TAG_W-1:0]   s1_tag_q, s1_tag_d;
    logic [EXP_W:0]     s1_exp_ab_q, s1_exp_ab_d;
    logic [DW-1:0]      s1_d_q, s1_d_d;
    logic [EXP_W-1:0]   s1_exp_c_q, s1_exp_c_d;

    logic               s2_valid_q, s2_valid_d;
    logic [EXP_W:0]     s2_exp_ab_q, s2_exp_ab_d;
    logic [DW-1:0]      s2_exp_tmp_q, s2_exp_tmp_d;
    logic [SHF_W-1:0]   s2_shf_q, s2_shf_d;
    logic               s2_c_dom_q, s2_c_dom_d;
    logic [TAG_W-1:0]   s2_tag_q, s2_tag_d;

    logic               s2_adv;
    logic signed [DW-1:0] ab_ofs, c_ext;
    logic signed [DW:0]   raw_shf;
    logic               c_gt;
    logic [SHF_W-1:0]   shf_fma;

    assign s2_adv   = out_ready | ~s2_valid_q;
    assign in_ready = ~rst & (~s1_valid_q | s2_adv);

    // Full-width signed compare and shift so extreme exponents never wrap before clamping.
    always_comb begin
        ab_ofs  = $signed({s1_exp_ab_q[EXP_W], s1_exp_ab_q}) + $signed(DW'(OFS));
        c_ext   = $signed({{2{s1_exp_c_q[EXP_W-1]}}, s1_exp_c_q});
        c_gt    = c_ext > ab_ofs;
        raw_shf = $signed((DW+1)'(OFS - 1)) - $signed({s1_d_q[DW-1], s1_d_q});
        if (raw_shf < 0)
            shf_fma = '0;
        else if (raw_shf > $signed((DW+1)'(SHF_MAX)))
            shf_fma = SHF_W'(SHF_MAX);
        else
            shf_fma = raw_shf[SHF_W-1:0];
    end

    always_comb begin
        s1_valid_d   = s1_valid_q;
        s1_mode_d    = s1_mode_q;
        s1_tag_d     = s1_tag_q;
        s1_exp_ab_d  = s1_exp_ab_q;
        s1_d_d       = s1_d_q;
        s1_exp_c_d   = s1_exp_c_q;
        s2_valid_d   = s2_valid_q;
        s2_exp_ab_d  = s2_exp_ab_q;
        s2_exp_tmp_d = s2_exp_tmp_q;
        s2_shf_d     = s2_shf_q;
        s2_c_dom_d   = s2_c_dom_q;
        s2_tag_d     = s2_tag_q;

        if (in_ready) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_mode_d   = in_mode;
                s1_tag_d    = in_tag;
                s1_exp_c_d  = exp_c;
                s1_exp_ab_d = {exp_a[EXP_W-1], exp_a} + {exp_b[EXP_W-1], exp_b};
                s1_d_d      = {{2{exp_c[EXP_W-1]}}, exp_c}
                            - {exp_a[EXP_W-1], exp_a[EXP_W-1], exp_a}
                            - {exp_b[EXP_W-1], exp_b[EXP_W-1], exp_b};
            end
        end

        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_exp_ab_d = s1_exp_ab_q;
                s2_tag_d    = s1_tag_q;
                if (s1_mode_q) begin
                    s2_exp_tmp_d = ab_ofs;
                    s2_shf_d     = SHF_W'(SHF_MAX);
                    s2_c_dom_d   = 1'b0;
                end else begin
                    s2_exp_tmp_d = c_gt ? c_ext : ab_ofs;
                    s2_shf_d     = shf_fma;
                    s2_c_dom_d   = c_gt;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q   <= 1'b0;
            s1_mode_q    <= 1'b0;
            s1_tag_q     <= '0;
            s1_exp_ab_q  <= '0;
            s1_d_q       <= '0;
            s1_exp_c_q   <= '0;
            s2_valid_q   <= 1'b0;
            s2_exp_ab_q  <= '0;
            s2_exp_tmp_q <= '0;
            s2_shf_q     <= '0;
            s2_c_dom_q   <= 1'b0;
            s2_tag_q     <= '0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_mode_q    <= s1_mode_d;
            s1_tag_q     <= s1_tag_d;
            s1_exp_ab_q  <= s1_exp_ab_d;
            s1_d_q       <= s1_d_d;
            s1_exp_c_q   <= s1_exp_c_d;
            s2_valid_q   <= s2_valid_d;
            s2_exp_ab_q  <= s2_exp_ab_d;
            s2_exp_tmp_q <= s2_exp_tmp_d;
            s2_shf_q     <= s2_shf_d;
            s2_c_dom_q   <= s2_c_dom_d;
            s2_tag_q     <= s2_tag_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign exp_ab    = s2_exp_ab_q;
    assign exp_tmp   = s2_exp_tmp_q;
    assign shf_num   = s2_shf_q;
    assign c_dom     = s2_c_dom_q;
    assign out_tag   = s2_tag_q;
endmodule

// File: tb/tb_fma_exp_pipe.sv
// tb/tb_fma_exp_pipe.sv - scoreboard bench for fma_exp_pipe
module tb_fma_exp_pipe;
    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_ready, in_mode;
    logic [7:0] exp_a, exp_b, exp_c;
    logic [3:0] in_tag;
    logic       out_valid, out_ready;
    logic [8:0] exp_ab;
    logic [9:0] exp_tmp;
    logic [6:0] shf_num;
    logic       c_dom;
    logic [3:0] out_tag;

    fma_exp_pipe dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
        .exp_a(exp_a), .exp_b(exp_b), .exp_c(exp_c), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .exp_ab(exp_ab), .exp_tmp(exp_tmp), .shf_num(shf_num),
        .c_dom(c_dom), .out_tag(out_tag)
    );

    always #5 clk = ~clk;

    typedef struct {
        int ab;
        int tmp;
        int shf;
        int cd;
        int tag;
        int cyc;
    } exp_t;

    exp_t sb[$];
    exp_t nxt;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   rcv = 0;
    int   dir_tag = 0;
    bit   acc;
    bit   lat_chk;

    task automatic check(input string name, input logic signed [31:0] got, input logic signed [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d (cycle %0d)", name, got, want, cyc);
        end
    endtask

    function automatic exp_t model(bit m, int a, int b, int c, int tag);
        exp_t e;
        int d, raw;
        e.ab  = a + b;
        e.tag = tag;
        e.cyc = 0;
        if (m) begin
            e.tmp = e.ab + 27;
            e.shf = 74;
            e.cd  = 0;
        end else begin
            e.cd  = (c > e.ab + 27) ? 1 : 0;
            e.tmp = (e.cd == 1) ? c : e.ab + 27;
            d     = c - e.ab;
            raw   = 26 - d;
            e.shf = (raw < 0) ? 0 : ((raw > 74) ? 74 : raw);
        end
        return e;
    endfunction

    // Called at a negedge with inputs already driven; the following posedge commits them.
    task automatic tick();
        exp_t e;
        #1;
        acc = 1'b0;
        if (!rst) begin
            check("in_ready", in_ready, (sb.size() == 2 && !out_ready) ? 0 : 1);
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("out_with_empty_sb", out_valid, 0);
                end else begin
                    e = sb.pop_front();
                    rcv++;
                    check("exp_ab", $signed(exp_ab), e.ab);
                    check("exp_tmp", $signed(exp_tmp), e.tmp);
                    check("shf_num", shf_num, e.shf);
                    check("c_dom", c_dom, e.cd);
                    check("out_tag", out_tag, e.tag);
                    if (lat_chk) check("latency", cyc - e.cyc, 2);
                end
            end
            if (in_valid && in_ready) begin
                nxt.cyc = cyc;
                sb.push_back(nxt);
                acc = 1'b1;
            end
        end else begin
            check("in_ready_rst", in_ready, 0);
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic run_dir(input bit m, input int a, input int b, input int c,
                           input int ab, input int tmp, input int shf, input int cd);
        in_mode  = m;
        exp_a    = a[7:0];
        exp_b    = b[7:0];
        exp_c    = c[7:0];
        in_tag   = dir_tag[3:0];
        nxt      = '{ab, tmp, shf, cd, dir_tag % 16, 0};
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        dir_tag++;
        for (int k = 0; k < 10 && sb.size() > 0; k++) tick();
        check("dir_drain", sb.size(), 0);
    endtask

    bit   rm[8];
    logic [7:0] ra[8], rb[8], rc[8];

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_mode = 1'b0;
        exp_a = '0; exp_b = '0; exp_c = '0; in_tag = '0;
        out_ready = 1'b1; lat_chk = 1'b0;
        @(negedge clk);
        repeat (3) tick();
        rst = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_exp_ab", exp_ab, 0);
        check("rst_exp_tmp", exp_tmp, 0);
        check("rst_shf_num", shf_num, 0);
        check("rst_c_dom", c_dom, 0);
        check("rst_out_tag", out_tag, 0);
        check("in_ready_after_rst", in_ready, 1);

        lat_chk = 1'b1;
        run_dir(0, 0, 0, 0, 0, 27, 26, 0);
        run_dir(0, 0, 0, 30, 0, 30, 0, 1);
        run_dir(0, 0, 0, 27, 0, 27, 0, 0);
        run_dir(0, 0, 0, 28, 0, 28, 0, 1);
        run_dir(0, 10, 0, 20, 10, 37, 16, 0);
        run_dir(0, 50, 50, 0, 100, 127, 74, 0);
        run_dir(0, -126, -126, 127, -252, 127, 0, 1);
        run_dir(1, 3, 4, 100, 7, 34, 74, 0);
        run_dir(1, -128, -128, 127, -256, -229, 74, 0);
        lat_chk = 1'b0;

        for (int i = 0; i < 8; i++) begin
            rm[i] = 1'($urandom_range(0, 1));
            ra[i] = 8'($urandom_range(0, 255));
            rb[i] = 8'($urandom_range(0, 255));
            rc[i] = 8'($urandom_range(0, 255));
        end
        rcv = 0;
        begin
            int i;
            i = 0;
            for (int k = 0; k < 300 && i < 8; k++) begin
                in_valid = 1'b1;
                in_mode  = rm[i];
                exp_a    = ra[i];
                exp_b    = rb[i];
                exp_c    = rc[i];
                in_tag   = 4'(i);
                nxt      = model(rm[i], $signed(ra[i]), $signed(rb[i]), $signed(rc[i]), i);
                out_ready = 1'($urandom_range(0, 1));
                tick();
                if (acc) i++;
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
            for (int k = 0; k < 20 && sb.size() > 0; k++) tick();
            check("rand_sent", i, 8);
            check("rand_count", rcv, 8);
        end

        out_ready = 1'b0;
        for (int t = 14; t < 16; t++) begin
            in_valid = 1'b1;
            in_mode  = 1'b0;
            exp_a = 8'd1; exp_b = 8'd2; exp_c = 8'd3;
            in_tag = 4'(t);
            nxt = model(0, 1, 2, 3, t);
            tick();
        end
        in_valid = 1'b0;
        tick();
        check("stall_in_ready", in_ready, 0);
        check("stall_out_tag", out_tag, 14);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb.delete();
        #1;
        check("flush_out_valid", out_valid, 0);
        check("flush_in_ready", in_ready, 1);
        out_ready = 1'b1;
        repeat (6) begin
            if (out_valid) check("flushed_tag_seen", out_tag, -1);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
